// File: rtl/sseg_scan_if.sv
// Display-side bundle between the output core and the seven-segment scanner.
// The core side (master) drives digit data; the scanner (slave) drives the display.
interface sseg_scan_if #(
  parameter int N_DIG = 8
);
  logic [4*N_DIG-1:0] hex_in;
  logic [N_DIG-1:0]   dp_in;
  logic [N_DIG-1:0]   en_in;
  logic [3:0]         bright;
  logic [N_DIG-1:0]   an;
  logic [7:0]         sseg;
  logic               frame_start;

  modport master (
    output hex_in, dp_in, en_in, bright,
    input  an, sseg, frame_start
  );

  modport slave (
    input  hex_in, dp_in, en_in, bright,
    output an, sseg, frame_start
  );
endinterface

// File: rtl/sseg_scan.sv
// Multiplexed common-anode seven-segment driver: one digit per slot, one dead
// cycle per slot, brightness PWM, and per-frame snapshot of the input word.
module sseg_scan #(
  parameter int N_DIG       = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  sseg_scan_if.slave disp
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]   dig_idx_q, dig_idx_d;
  logic [3:0]         pwm_cnt_q, pwm_cnt_d;
  logic [4*N_DIG-1:0] hex_s_q;
  logic [N_DIG-1:0]   dp_s_q;
  logic [N_DIG-1:0]   en_s_q;
  logic [3:0]         bright_s_q;
  logic               load_pend_q;
  logic [N_DIG-1:0]   an_q, an_d;
  logic [7:0]         sseg_q, sseg_d;
  logic               frame_start_q, frame_start_d;
  logic               slot_end;
  logic               load;
  logic               digit_on;
  logic [3:0]         hex_dig [N_DIG];

  for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
    assign hex_dig[gi] = hex_s_q[4*gi +: 4];
  end

  // Active-low g..a patterns
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end  = (div_cnt_q == DIV_LAST);
    div_cnt_d = slot_end ? '0 : div_cnt_q + 1'b1;
    dig_idx_d = dig_idx_q;
    if (slot_end) begin
      dig_idx_d = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + 1'b1;
    end
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    load      = load_pend_q || (slot_end && (dig_idx_q == IDX_LAST));

    // Slot cycle 0 is dead time so the previous digit's anode is fully off.
    digit_on = (div_cnt_q != '0) && en_s_q[dig_idx_q] && (pwm_cnt_q <= bright_s_q);
    an_d = '1;
    if (digit_on) begin
      an_d[dig_idx_q] = 1'b0;
    end
    sseg_d        = {~dp_s_q[dig_idx_q], seg_decode(hex_dig[dig_idx_q])};
    frame_start_d = (div_cnt_q == '0) && (dig_idx_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q     <= '0;
      dig_idx_q     <= '0;
      pwm_cnt_q     <= '0;
      hex_s_q       <= '0;
      dp_s_q        <= '0;
      en_s_q        <= '0;
      bright_s_q    <= '0;
      load_pend_q   <= 1'b1;
      an_q          <= '1;
      sseg_q        <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      dig_idx_q     <= dig_idx_d;
      pwm_cnt_q     <= pwm_cnt_d;
      load_pend_q   <= 1'b0;
      an_q          <= an_d;
      sseg_q        <= sseg_d;
      frame_start_q <= frame_start_d;
      if (load) begin
        hex_s_q    <= disp.hex_in;
        dp_s_q     <= disp.dp_in;
        en_s_q     <= disp.en_in;
        bright_s_q <= disp.bright;
      end
    end
  end

  assign disp.an          = an_q;
  assign disp.sseg        = sseg_q;
  assign disp.frame_start = frame_start_q;

endmodule

// File: tb/tb_sseg_scan.sv
// Bench for sseg_scan: three instances (4x8, 4x64, 1x4) checked every cycle
// against a slot/frame arithmetic model, plus decode table and corner sequences.
module tb_sseg_scan;

  typedef struct {
    logic [31:0] hex;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic [3:0]  br;
  } snap_t;

  typedef struct {
    logic [3:0] val;
    logic       dp;
    logic [7:0] exp;
  } dec_vec_t;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   t = 0;
  int   out_t = 0;
  snap_t sa, sb, sc;

  always #5 clk = ~clk;

  sseg_scan_if #(.N_DIG(4)) if_a ();
  sseg_scan_if #(.N_DIG(4)) if_b ();
  sseg_scan_if #(.N_DIG(1)) if_c ();

  sseg_scan #(.N_DIG(4), .REFRESH_DIV(8))  dut_a (.clk(clk), .reset(reset), .disp(if_a));
  sseg_scan #(.N_DIG(4), .REFRESH_DIV(64)) dut_b (.clk(clk), .reset(reset), .disp(if_b));
  sseg_scan #(.N_DIG(1), .REFRESH_DIV(4))  dut_c (.clk(clk), .reset(reset), .disp(if_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, out_t, act, exp);
    end
  endtask

  // Expected outputs after the edge that leaves state t (t edges since reset release).
  function automatic void model(input int tt, input int n, input int r, input snap_t s,
                                output logic [7:0] an, output logic [7:0] sg, output logic fs);
    int div, idx;
    logic on;
    logic [3:0] h;
    div = tt % r;
    idx = (tt / r) % n;
    h   = s.hex[idx*4 +: 4];
    on  = (div != 0) && s.en[idx] && ((tt % 16) <= int'(s.br));
    an  = '0;
    for (int i = 0; i < n; i++) an[i] = 1'b1;
    if (on) an[idx] = 1'b0;
    sg  = {~s.dp[idx], SEG_TAB[h]};
    fs  = (tt % (n * r)) == 0;
  endfunction

  function automatic logic loads(input int tt, input int n, input int r);
    return (tt == 0) || (((tt + 1) % (n * r)) == 0);
  endfunction

  task automatic step();
    logic [7:0] ea_an, ea_sg, eb_an, eb_sg, ec_an, ec_sg;
    logic ea_fs, eb_fs, ec_fs;
    snap_t na, nb, nc;
    model(t, 4, 8,  sa, ea_an, ea_sg, ea_fs);
    model(t, 4, 64, sb, eb_an, eb_sg, eb_fs);
    model(t, 1, 4,  sc, ec_an, ec_sg, ec_fs);
    na = '{32'(if_a.hex_in), 8'(if_a.dp_in), 8'(if_a.en_in), if_a.bright};
    nb = '{32'(if_b.hex_in), 8'(if_b.dp_in), 8'(if_b.en_in), if_b.bright};
    nc = '{32'(if_c.hex_in), 8'(if_c.dp_in), 8'(if_c.en_in), if_c.bright};
    @(posedge clk);
    #1;
    if (loads(t, 4, 8))  sa = na;
    if (loads(t, 4, 64)) sb = nb;
    if (loads(t, 1, 4))  sc = nc;
    out_t = t;
    t++;
    chk("a_an",   32'(if_a.an),          32'(ea_an));
    chk("a_sseg", 32'(if_a.sseg),        32'(ea_sg));
    chk("a_fs",   32'(if_a.frame_start), 32'(ea_fs));
    chk("b_an",   32'(if_b.an),          32'(eb_an));
    chk("b_fs",   32'(if_b.frame_start), 32'(eb_fs));
    chk("c_an",   32'(if_c.an),          32'(ec_an));
    chk("c_sseg", 32'(if_c.sseg),        32'(ec_sg));
    chk("c_fs",   32'(if_c.frame_start), 32'(ec_fs));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a_an"},   32'(if_a.an),          32'h0000_000F);
    chk({tag, "_a_sseg"}, 32'(if_a.sseg),        32'h0000_00FF);
    chk({tag, "_a_fs"},   32'(if_a.frame_start), 32'h0);
    chk({tag, "_b_an"},   32'(if_b.an),          32'h0000_000F);
    chk({tag, "_c_an"},   32'(if_c.an),          32'h1);
    chk({tag, "_c_sseg"}, 32'(if_c.sseg),        32'h0000_00FF);
  endtask

  task automatic model_reset();
    t  = 0;
    sa = '{32'h0, 8'h0, 8'h0, 4'h0};
    sb = sa;
    sc = sa;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d actual=timeout required=finish", t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    dec_vec_t vecs [20];
    logic [7:0] slot_sseg [4];
    int b_on, a_fs_cnt, slot;
    logic [3:0] exp_an;

    for (int v = 0; v < 16; v++) vecs[v] = '{4'(v), 1'b1, {1'b0, SEG_TAB[v]}};
    vecs[16] = '{4'h0, 1'b0, 8'hC0};
    vecs[17] = '{4'h8, 1'b0, 8'h80};
    vecs[18] = '{4'hF, 1'b0, 8'h8E};
    vecs[19] = '{4'hB, 1'b0, 8'h83};
    slot_sseg[0] = 8'hC0; slot_sseg[1] = 8'hF9; slot_sseg[2] = 8'hA4; slot_sseg[3] = 8'hB0;

    reset = 1'b1;
    if_a.hex_in = 16'h3210; if_a.dp_in = 4'h0; if_a.en_in = 4'hF; if_a.bright = 4'd15;
    if_b.hex_in = 16'h0000; if_b.dp_in = 4'h0; if_b.en_in = 4'hF; if_b.bright = 4'd0;
    if_c.hex_in = 4'h5;     if_c.dp_in = 1'b0; if_c.en_in = 1'b1; if_c.bright = 4'd15;
    model_reset();
    #7;
    chk_reset_vals("rst");
    #1 reset = 1'b0;

    // Scan order, frame pulses, bright=0 duty and single-digit pattern
    b_on = 0;
    a_fs_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (if_b.an != 4'hF) b_on++;
      if (if_a.frame_start) a_fs_cnt++;
      if (k < 64) begin
        slot = (out_t / 8) % 4;
        exp_an = ((out_t % 8) == 0) ? 4'hF : (4'hF & ~(4'b0001 << slot));
        chk("scan_an", 32'(if_a.an), 32'(exp_an));
        chk("scan_sseg", 32'(if_a.sseg), 32'(slot_sseg[slot]));
      end
      chk("n1_an", 32'(if_c.an), ((out_t % 4) == 0) ? 32'h1 : 32'h0);
    end
    chk("bright0_on_cycles", b_on, 12);
    chk("frame_pulses", a_fs_cnt, 8);
    $display("scan: b_on=%0d frame_pulses=%0d", b_on, a_fs_cnt);

    // Decode table
    for (int i = 0; i < 20; i++) begin
      if_a.hex_in = {4{vecs[i].val}};
      if_a.dp_in  = {4{vecs[i].dp}};
      repeat (33) step();
      chk("decode", 32'(if_a.sseg), 32'(vecs[i].exp));
      $display("decode: val=%h dp=%b sseg=%h exp=%h", vecs[i].val, vecs[i].dp, if_a.sseg, vecs[i].exp);
    end

    // Snapshot coherence: change data during digit 1's slot
    if_a.hex_in = 16'h1111; if_a.dp_in = 4'h0;
    repeat (40) step();
    while ((t % 32) != 12) step();
    if_a.hex_in = 16'h2222;
    while ((t % 32) != 0) begin
      step();
      if (((out_t / 8) % 4) >= 2) chk("coh_old", 32'(if_a.sseg), 32'h0000_00F9);
    end
    for (int k = 0; k < 32; k++) begin
      step();
      if (k == 0) chk("coh_fs", 32'(if_a.frame_start), 32'h1);
      chk("coh_new", 32'(if_a.sseg), 32'h0000_00A4);
    end
    $display("coherence: final sseg=%h", if_a.sseg);

    // Blanking of disabled digits
    if_a.en_in = 4'b0101; if_a.bright = 4'd9;
    repeat (40) step();
    for (int k = 0; k < 32; k++) begin
      step();
      if (((out_t / 8) % 2) == 1) chk("blank_an", 32'(if_a.an), 32'h0000_000F);
    end
    $display("blanking: done");

    // Short asynchronous reset inside digit 2's slot
    if_a.en_in = 4'hF; if_a.bright = 4'd15; if_a.hex_in = 16'h3210;
    while ((t % 32) != 20) step();
    #1 reset = 1'b1;
    #1 chk_reset_vals("async");
    #1 reset = 1'b0;
    model_reset();
    step();
    chk("restart_fs", 32'(if_a.frame_start), 32'h1);
    repeat (40) step();
    $display("async reset: restart checked");

    // Randomised inputs against the model
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(7) == 0) begin
        if_a.hex_in = 16'($urandom);
        if_a.dp_in  = 4'($urandom);
        if_a.en_in  = 4'($urandom);
        if_a.bright = 4'($urandom);
      end
      if ($urandom_range(5) == 0) begin
        if_c.hex_in = 4'($urandom);
        if_c.dp_in  = 1'($urandom);
        if_c.en_in  = 1'($urandom);
        if_c.bright = 4'($urandom);
      end
      step();
    end
    $display("random: 1500 cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
